// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer around the PC register: memory req/ack, decode valid/ready, redirects.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky fetch_misaligned flag for unaligned redirect targets.
module fetch_sequencer #(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_out,
    output logic            pc_load,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, VALID, DRAIN} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_buf_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] redir_q, redir_d;
    fetch_buf_t      buf_q;
    logic            buf_ld;
    logic            pc_load_c;
    logic [XLEN-1:0] tgt;
    logic            redir_ok;
    logic            redir_bad;
    logic            halted;

    assign tgt = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    // An unaligned target is never loaded; once flagged, redirects are ignored until reset.
    assign redir_bad = redirect & (|redirect_pc[1:0]);
    assign redir_ok  = redirect & ~(|redirect_pc[1:0]) & ~misaligned_q;
    assign halted    = misaligned_q;
    assign fetch_misaligned = misaligned_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         misaligned_q <= 1'b0;
        else if (redir_bad) misaligned_q <= 1'b1;
    end
`else
    assign redir_bad = 1'b0;
    assign redir_ok  = redirect;
    assign halted    = 1'b0;
`endif

    assign imem_addr = addr_q;
    assign imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign if_valid  = (state_q == VALID);
    assign if_instr  = buf_q.instr;
    assign if_pc     = buf_q.pc;
    // Gated so pc_load drops the instant reset is asserted, even with redirect high in IDLE.
    assign pc_load   = pc_load_c & reset;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        redir_d   = redir_q;
        buf_ld    = 1'b0;
        pc_load_c = 1'b0;
        pc_out    = tgt;
        case (state_q)
            IDLE: begin
                if (!halted) begin
                    if (redirect) begin
                        if (redir_ok) begin
                            addr_d    = tgt;
                            pc_load_c = 1'b1;
                            state_d   = REQ;
                        end
                    end else if (!stall) begin
                        addr_d  = pc_in;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_load_c = redir_ok;
                    if (imem_ack) begin
                        if (redir_ok) begin
                            addr_d  = tgt;
                            state_d = REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        redir_d = tgt;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    buf_ld    = 1'b1;
                    pc_load_c = 1'b1;
                    pc_out    = addr_q + XLEN'(PC_STEP);
                    state_d   = VALID;
                end
            end
            VALID: begin
                if (redirect) begin
                    if (redir_ok) begin
                        addr_d    = tgt;
                        pc_load_c = 1'b1;
                        state_d   = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (if_ready) begin
                    if (!stall) begin
                        addr_d  = pc_in;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // Old request stays on the bus until its ack arrives; that data is dropped.
                if (redir_ok) begin
                    redir_d   = tgt;
                    pc_load_c = 1'b1;
                end
                if (imem_ack) begin
                    addr_d  = redir_ok ? tgt : redir_q;
                    state_d = (halted || redir_bad) ? IDLE : REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            redir_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            redir_q <= redir_d;
            if (buf_ld) begin
                buf_q.instr <= imem_rdata;
                buf_q.pc    <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC register around it.
module tb_fetch_sequencer;
    localparam int XLEN = 64;
    localparam int ILEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_out;
    logic            pc_load;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            if_valid;
    logic            if_ready;
    logic [ILEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic            fetch_misaligned;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset)       pc_reg <= '0;
        else if (pc_load) pc_reg <= pc_out;
    end

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .pc_in(pc_reg), .pc_out(pc_out), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall)
`ifdef FETCH_MISALIGN_CHECK_EN
        , .fetch_misaligned(fetch_misaligned)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc_reg = '0; imem_ack = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", if_valid); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rst_pcload got %b exp 0", pc_load); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (if_instr !== 32'h0 || if_pc !== 64'h0) begin errors++; $display("FAIL rst_buf got %h/%h exp 0/0", if_instr, if_pc); end
        #8 reset = 1'b1;
    endtask

    task automatic test_first_fetch();
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL first_req got %b/%h exp 1/0", imem_req, imem_addr); end
        tick();
        checks++; if (imem_req !== 1'b1 || pc_load !== 1'b0) begin errors++; $display("FAIL first_wait got req %b load %b exp 1/0", imem_req, pc_load); end
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0013; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h4) begin errors++; $display("FAIL first_pc got %b/%h exp 1/4", pc_load, pc_out); end
        tick();
        imem_ack = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'h13 || if_pc !== 64'h0) begin errors++; $display("FAIL first_out got %b/%h/%h exp 1/13/0", if_valid, if_instr, if_pc); end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (if_valid !== 1'b1 || if_instr !== 32'h13 || if_pc !== 64'h0 || imem_req !== 1'b0 || pc_load !== 1'b0) begin
                errors++; $display("FAIL hold%0d got v%b i%h pc%h req%b ld%b exp v1 i13 pc0 req0 ld0", i, if_valid, if_instr, if_pc, imem_req, pc_load);
            end
        end
        if_ready = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h4 || if_valid !== 1'b0) begin errors++; $display("FAIL hold_next got %b/%h/%b exp 1/4/0", imem_req, imem_addr, if_valid); end
    endtask

    task automatic test_back_to_back();
        imem_ack = 1'b1; imem_rdata = 32'h0000_000A; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h8) begin errors++; $display("FAIL b2b_pc got %b/%h exp 1/8", pc_load, pc_out); end
        tick();
        imem_ack = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'hA || if_pc !== 64'h4) begin errors++; $display("FAIL b2b_out got %b/%h/%h exp 1/a/4", if_valid, if_instr, if_pc); end
        tick();
        if_ready = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin errors++; $display("FAIL b2b_req got %b/%h exp 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_drain();
        redirect = 1'b1; redirect_pc = 64'h100; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h100) begin errors++; $display("FAIL drain_pc got %b/%h exp 1/100", pc_load, pc_out); end
        tick();
        redirect = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8 || pc_load !== 1'b0) begin errors++; $display("FAIL drain_hold got %b/%h/%b exp 1/8/0", imem_req, imem_addr, pc_load); end
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin errors++; $display("FAIL drain_hold2 got %b/%h exp 1/8", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL drain_ack_load got %b exp 0", pc_load); end
        tick();
        imem_ack = 1'b0; #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin errors++; $display("FAIL drain_next got %b/%b/%h exp 0/1/100", if_valid, imem_req, imem_addr); end
        checks++; if (pc_reg !== 64'h100) begin errors++; $display("FAIL drain_pcreg got %h exp 100", pc_reg); end
    endtask

    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD; redirect = 1'b1; redirect_pc = 64'h200; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h200) begin errors++; $display("FAIL rack_pc got %b/%h exp 1/200", pc_load, pc_out); end
        tick();
        imem_ack = 1'b0; redirect = 1'b0; #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h200) begin errors++; $display("FAIL rack_next got %b/%b/%h exp 0/1/200", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0011; if_ready = 1'b1; stall = 1'b1; #1;
        checks++; if (pc_out !== 64'h204) begin errors++; $display("FAIL stall_pc got %h exp 204", pc_out); end
        tick();
        imem_ack = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 64'h200 || if_instr !== 32'h11) begin errors++; $display("FAIL stall_out got %b/%h/%h exp 1/200/11", if_valid, if_pc, if_instr); end
        tick();
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle got %b/%b exp 0/0", if_valid, imem_req); end
        tick();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_idle2 got %b exp 0", imem_req); end
        stall = 1'b0; if_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h204) begin errors++; $display("FAIL stall_release got %b/%h exp 1/204", imem_req, imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0; imem_rdata = 32'h0000_0077; #1;
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffffffffffc", imem_addr); end
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h0) begin errors++; $display("FAIL wrap_pc got %b/%h exp 1/0", pc_load, pc_out); end
        tick();
        imem_ack = 1'b0; #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || if_instr !== 32'h77) begin errors++; $display("FAIL wrap_out got %b/%h/%h", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_valid();
        redirect = 1'b1; redirect_pc = 64'h300; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h300) begin errors++; $display("FAIL rval_pc got %b/%h exp 1/300", pc_load, pc_out); end
        tick();
        redirect = 1'b0; #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h300) begin errors++; $display("FAIL rval_next got %b/%b/%h exp 0/1/300", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_async_reset();
        #1 reset = 1'b0; redirect = 1'b1; redirect_pc = 64'h400; #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc_load !== 1'b0) begin errors++; $display("FAIL arst got %b/%b/%b exp 0/0/0", imem_req, if_valid, pc_load); end
        checks++; if (imem_addr !== 64'h0) begin errors++; $display("FAIL arst_addr got %h exp 0", imem_addr); end
        redirect = 1'b0; redirect_pc = '0;
        #2 reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL arst_restart got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

`ifdef FETCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL mis_init got %b exp 0", fetch_misaligned); end
        redirect = 1'b1; redirect_pc = 64'h102; #1;
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL mis_load got %b exp 0", pc_load); end
        tick();
        redirect = 1'b0; #1;
        checks++; if (fetch_misaligned !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL mis_drain got %b/%b/%h exp 1/1/0", fetch_misaligned, imem_req, imem_addr); end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || fetch_misaligned !== 1'b1) begin errors++; $display("FAIL mis_park%0d got %b/%b/%b exp 0/0/1", i, imem_req, if_valid, fetch_misaligned); end
        end
    endtask
`else
    task automatic test_low_bits();
        imem_ack = 1'b1; redirect = 1'b1; redirect_pc = 64'h203; #1;
        checks++; if (pc_load !== 1'b1 || pc_out !== 64'h200) begin errors++; $display("FAIL lowbits_pc got %b/%h exp 1/200", pc_load, pc_out); end
        tick();
        imem_ack = 1'b0; redirect = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin errors++; $display("FAIL lowbits_addr got %b/%h exp 1/200", imem_req, imem_addr); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_first_fetch();
        test_hold();
        test_back_to_back();
        test_redirect_drain();
        test_redirect_ack();
        test_stall();
        test_wrap();
        test_redirect_valid();
        test_async_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
        test_misalign();
`else
        test_low_bits();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
